// File: rtl/eth_pkg.sv
// Shared types and framing constants for the byte-wide Ethernet transmit/receive pair.
package eth_pkg;

  typedef logic [47:0] mac_addr_t;

  typedef enum logic [3:0] {
    IDLE,
    LOAD,
    WAIT_RDY,
    PREAMBLE,
    SFD,
    DST,
    SRC,
    LEN,
    PL,
    FCS
  } tx_state_t;

  localparam logic [7:0] PREAMBLE_BYTE = 8'hAA;
  localparam logic [7:0] SFD_BYTE      = 8'hAB;
  localparam int         PREAMBLE_LEN  = 7;
  localparam int         MAC_LEN       = 6;
  localparam int         LEN_LEN       = 2;
  localparam int         FCS_LEN       = 4;

  // MAC addresses go on the wire least-significant byte first.
  function automatic logic [7:0] mac_byte(input mac_addr_t mac, input logic [2:0] idx);
    mac_addr_t shifted;
    shifted = mac >> {idx, 3'b000};
    return shifted[7:0];
  endfunction

endpackage

// File: rtl/eth_tx_buf.sv
// Payload buffer: one write per cycle while loading, combinational read while emitting.
module eth_tx_buf #(
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [7:0]    wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [7:0]    rdata_o
);

  logic [7:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/eth_frame_tx.sv
// Buffers a payload, then emits a gap-free frame (preamble, SFD, MACs, length,
// payload, LRC-based FCS) into the byte-wide receiver.
module eth_frame_tx
  import eth_pkg::*;
#(
  parameter mac_addr_t SRC_MAC_ADDR = 48'h02_00_00_00_00_01,
  parameter int        MAX_LEN      = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic [15:0] req_len,
  input  mac_addr_t   req_dst_mac,
  output logic        req_ready,
  output logic        req_err,
  input  logic [7:0]  pl_data,
  input  logic        pl_vld,
  output logic        pl_rdy,
  input  logic        rx_ready,
  output logic [7:0]  tx_data,
  output logic        tx_start,
  output logic        tx_active,
  output logic        done
);

  localparam int          AW        = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [15:0] MAX_LEN_W = 16'(MAX_LEN);
  localparam logic [15:0] PRE_LAST  = 16'(PREAMBLE_LEN - 1);
  localparam logic [15:0] MAC_LAST  = 16'(MAC_LEN - 1);
  localparam logic [15:0] LEN_LAST  = 16'(LEN_LEN - 1);
  localparam logic [15:0] FCS_LAST  = 16'(FCS_LEN - 1);

  tx_state_t   state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] count_q, count_d;
  logic [15:0] len_q, len_d;
  mac_addr_t   dst_q, dst_d;
  logic [7:0]  sum_q, sum_d;
  logic        done_q, done_d;
  logic        buf_we;
  logic [7:0]  buf_rdata;

  eth_tx_buf #(
    .DEPTH (MAX_LEN),
    .AW    (AW)
  ) u_buf (
    .clk     (clk),
    .we_i    (buf_we),
    .waddr_i (count_q[AW-1:0]),
    .wdata_i (pl_data),
    .raddr_i (cnt_q[AW-1:0]),
    .rdata_o (buf_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      count_q <= '0;
      len_q   <= '0;
      dst_q   <= '0;
      sum_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      count_q <= count_d;
      len_q   <= len_d;
      dst_q   <= dst_d;
      sum_q   <= sum_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    len_d     = len_q;
    dst_d     = dst_q;
    sum_d     = sum_q;
    req_ready = 1'b0;
    req_err   = 1'b0;
    pl_rdy    = 1'b0;
    buf_we    = 1'b0;
    tx_data   = 8'h00;
    tx_start  = 1'b0;
    tx_active = 1'b0;

    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req) begin
          if (req_len != 16'd0 && req_len <= MAX_LEN_W) begin
            len_d   = req_len;
            dst_d   = req_dst_mac;
            count_d = '0;
            state_d = LOAD;
          end else begin
            req_err = 1'b1;
          end
        end
      end
      LOAD: begin
        pl_rdy = (count_q < len_q);
        if (pl_vld && pl_rdy) begin
          buf_we  = 1'b1;
          count_d = count_q + 16'd1;
          if (count_q == len_q - 16'd1) state_d = WAIT_RDY;
        end
      end
      WAIT_RDY: begin
        if (rx_ready) begin
          sum_d   = '0;
          state_d = PREAMBLE;
        end
      end
      PREAMBLE: begin
        tx_active = 1'b1;
        tx_data   = PREAMBLE_BYTE;
        tx_start  = (cnt_q == 16'd0);
        if (cnt_q == PRE_LAST) state_d = SFD;
      end
      SFD: begin
        tx_active = 1'b1;
        tx_data   = SFD_BYTE;
        state_d   = DST;
      end
      DST: begin
        tx_active = 1'b1;
        tx_data   = mac_byte(dst_q, cnt_q[2:0]);
        sum_d     = sum_q + tx_data;
        if (cnt_q == MAC_LAST) state_d = SRC;
      end
      SRC: begin
        tx_active = 1'b1;
        tx_data   = mac_byte(SRC_MAC_ADDR, cnt_q[2:0]);
        sum_d     = sum_q + tx_data;
        if (cnt_q == MAC_LAST) state_d = LEN;
      end
      LEN: begin
        tx_active = 1'b1;
        tx_data   = cnt_q[0] ? len_q[15:8] : len_q[7:0];
        sum_d     = sum_q + tx_data;
        if (cnt_q == LEN_LAST) state_d = PL;
      end
      PL: begin
        tx_active = 1'b1;
        tx_data   = buf_rdata;
        sum_d     = sum_q + tx_data;
        if (cnt_q == len_q - 16'd1) state_d = FCS;
      end
      FCS: begin
        tx_active = 1'b1;
        tx_data   = ~sum_q + 8'd1;
        if (cnt_q == FCS_LAST) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // The in-state counter restarts on every transition so each field indexes from zero.
    cnt_d  = (state_d != state_q) ? 16'd0 : cnt_q + 16'd1;
    done_d = (state_q == FCS) && (state_d == IDLE);
  end

  assign done = done_q;

endmodule

// File: tb/tb_eth_frame_tx.sv
// Directed and randomized frames checked against a byte-list model of the frame format.
module tb_eth_frame_tx;

  localparam logic [47:0] SRC_MAC = 48'h02_00_00_00_00_01;

  logic        clk;
  logic        rst;
  logic        req;
  logic [15:0] req_len;
  logic [47:0] req_dst_mac;
  logic        req_ready;
  logic        req_err;
  logic [7:0]  pl_data;
  logic        pl_vld;
  logic        pl_rdy;
  logic        rx_ready;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic        tx_active;
  logic        done;

  int passCount  = 0;
  int failCount  = 0;
  int totalCount = 0;

  eth_frame_tx #(
    .SRC_MAC_ADDR (SRC_MAC),
    .MAX_LEN      (64)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .req_len     (req_len),
    .req_dst_mac (req_dst_mac),
    .req_ready   (req_ready),
    .req_err     (req_err),
    .pl_data     (pl_data),
    .pl_vld      (pl_vld),
    .pl_rdy      (pl_rdy),
    .rx_ready    (rx_ready),
    .tx_data     (tx_data),
    .tx_start    (tx_start),
    .tx_active   (tx_active),
    .done        (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic nextCycle;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    totalCount++;
    assert (observed === expected) begin
      passCount++;
    end else begin
      failCount++;
      $error("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  task automatic checkIdle(input string tag);
    checkOutput({tag, ".req_ready"}, 64'(req_ready), 64'd1);
    checkOutput({tag, ".req_err"},   64'(req_err),   64'd0);
    checkOutput({tag, ".pl_rdy"},    64'(pl_rdy),    64'd0);
    checkOutput({tag, ".tx_data"},   64'(tx_data),   64'd0);
    checkOutput({tag, ".tx_start"},  64'(tx_start),  64'd0);
    checkOutput({tag, ".tx_active"}, 64'(tx_active), 64'd0);
    checkOutput({tag, ".done"},      64'(done),      64'd0);
  endtask

  // One full transaction: request, payload load, optional rx_ready delay, frame, done.
  // abortAt >= 0 asserts rst while that frame byte index is on the wire.
  task automatic applyStimulus(input logic [47:0] dst, input int len, input bit toggle,
                               input int rxDelay, input int abortAt);
    logic [7:0] pl[$];
    logic [7:0] expQ[$];
    logic [7:0] b;
    int sum;
    int idx;
    int cyc;

    for (int i = 0; i < len; i++) pl.push_back(8'($urandom_range(0, 255)));

    sum = 0;
    for (int i = 0; i < 7; i++) expQ.push_back(8'hAA);
    expQ.push_back(8'hAB);
    for (int i = 0; i < 6; i++) begin
      b = 8'(dst >> (8 * i));
      expQ.push_back(b);
      sum += b;
    end
    for (int i = 0; i < 6; i++) begin
      b = 8'(SRC_MAC >> (8 * i));
      expQ.push_back(b);
      sum += b;
    end
    b = 8'(len);
    expQ.push_back(b);
    sum += b;
    b = 8'(len >> 8);
    expQ.push_back(b);
    sum += b;
    for (int i = 0; i < len; i++) begin
      expQ.push_back(pl[i]);
      sum += pl[i];
    end
    b = 8'((256 - (sum % 256)) % 256);
    for (int i = 0; i < 4; i++) expQ.push_back(b);

    nextCycle;
    req         = 1'b1;
    req_len     = 16'(len);
    req_dst_mac = dst;
    rx_ready    = (rxDelay == 0);
    #1;
    checkOutput("req.req_ready", 64'(req_ready), 64'd1);
    checkOutput("req.req_err",   64'(req_err),   64'd0);

    nextCycle;
    req = 1'b0;
    idx = 0;
    cyc = 0;
    while (idx < len && cyc < 4 * len + 8) begin
      pl_vld  = toggle ? (cyc % 2 == 0) : 1'b1;
      pl_data = pl[idx];
      #1;
      checkOutput("load.pl_rdy",    64'(pl_rdy),    64'd1);
      checkOutput("load.tx_active", 64'(tx_active), 64'd0);
      if (pl_vld) idx++;
      cyc++;
      nextCycle;
    end
    if (idx != len) checkOutput("load.timeout", 64'(idx), 64'(len));

    pl_vld = 1'b0;
    #1;
    checkOutput("wait.pl_rdy",    64'(pl_rdy),    64'd0);
    checkOutput("wait.req_ready", 64'(req_ready), 64'd0);
    checkOutput("wait.tx_active", 64'(tx_active), 64'd0);
    if (rxDelay > 0) begin
      for (int i = 1; i < rxDelay; i++) begin
        nextCycle;
        #1;
        checkOutput("wait.held.tx_active", 64'(tx_active), 64'd0);
        checkOutput("wait.held.tx_data",   64'(tx_data),   64'd0);
      end
      nextCycle;
      rx_ready = 1'b1;
      #1;
      checkOutput("wait.rise.tx_active", 64'(tx_active), 64'd0);
    end

    for (int k = 0; k < expQ.size(); k++) begin
      nextCycle;
      if (k == abortAt) rst = 1'b1;
      #1;
      checkOutput($sformatf("frame[%0d].tx_active", k), 64'(tx_active), 64'd1);
      checkOutput($sformatf("frame[%0d].tx_data", k),   64'(tx_data),   64'(expQ[k]));
      checkOutput($sformatf("frame[%0d].tx_start", k),  64'(tx_start),  64'(k == 0));
      if (k == abortAt) begin
        nextCycle;
        rst = 1'b0;
        #1;
        checkIdle("abort");
        return;
      end
    end

    nextCycle;
    #1;
    checkOutput("end.done",      64'(done),      64'd1);
    checkOutput("end.req_ready", 64'(req_ready), 64'd1);
    checkOutput("end.tx_active", 64'(tx_active), 64'd0);
    checkOutput("end.tx_data",   64'(tx_data),   64'd0);
    nextCycle;
    #1;
    checkOutput("end.done_pulse", 64'(done), 64'd0);
  endtask

  initial begin
    rst         = 1'b1;
    req         = 1'b0;
    req_len     = '0;
    req_dst_mac = '0;
    pl_data     = '0;
    pl_vld      = 1'b0;
    rx_ready    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkIdle("reset");
    rst = 1'b0;

    applyStimulus(48'h00_0a_95_9d_68_16, 1, 1'b0, 0, -1);

    nextCycle;
    req     = 1'b1;
    req_len = 16'd0;
    #1;
    checkOutput("len0.req_err",   64'(req_err),   64'd1);
    checkOutput("len0.req_ready", 64'(req_ready), 64'd1);
    checkOutput("len0.pl_rdy",    64'(pl_rdy),    64'd0);
    nextCycle;
    req_len = 16'd65;
    #1;
    checkOutput("len65.req_err",   64'(req_err),   64'd1);
    checkOutput("len65.req_ready", 64'(req_ready), 64'd1);
    checkOutput("len65.pl_rdy",    64'(pl_rdy),    64'd0);
    nextCycle;
    req = 1'b0;
    #1;
    checkIdle("afterIllegal");

    applyStimulus(48'h11_22_33_44_55_66, 64, 1'b1, 0, -1);
    applyStimulus(48'hA1_B2_C3_D4_E5_F6, 5, 1'b0, 10, -1);
    applyStimulus(48'h01_02_03_04_05_06, 20, 1'b0, 0, 22 + 10);
    applyStimulus(48'hDE_AD_BE_EF_00_42, 3, 1'b0, 0, -1);

    for (int n = 0; n < 10; n++) begin
      applyStimulus({16'($urandom), $urandom}, int'($urandom_range(1, 64)),
                    1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), -1);
    end

    $display("%0d/%0d checks passed", passCount, totalCount);
    $finish;
  end

endmodule
